// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with branch/JAL/JALR/trap redirect,
// stall-time redirect buffering and misaligned-target trapping.
// Optional redirect counter enabled by defining PC_GEN_REDIR_CNT_EN.
// ---------------------------------------------------------------------------
// Module   : pc_gen
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bra_addr,
  input  logic [ADDR_WIDTH-1:0] jal_addr,
  input  logic [ADDR_WIDTH-1:0] jalr_addr,
  input  logic [ADDR_WIDTH-1:0] trap_vec,
  input  logic                  redir_valid,
  input  logic [1:0]            redir_type,
  input  logic                  stall,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  redir_pending,
  output logic                  misalign_trap,
  output logic [ADDR_WIDTH-1:0] misalign_addr
`ifdef PC_GEN_REDIR_CNT_EN
  ,
  output logic [31:0]           redir_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_BRA  = 2'b00;
  localparam logic [1:0] TYPE_JAL  = 2'b01;
  localparam logic [1:0] TYPE_JALR = 2'b10;
  localparam logic [1:0] TYPE_TRAP = 2'b11;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pend_tgt;
  logic                    pend_trap;

  logic [ADDR_WIDTH-1:0]   tgt;
  logic                    misal;
  logic [ADDR_WIDTH-1:0]   final_tgt;
  logic                    is_trap;
  logic                    keep_pending;
  logic [ADDR_WIDTH-1:0]   hold_tgt;
  logic                    hold_trap;

  always_comb begin
    tgt = bra_addr;
    case (redir_type)
      TYPE_BRA:  tgt = bra_addr;
      TYPE_JAL:  tgt = jal_addr;
      TYPE_JALR: tgt = jalr_addr;
      TYPE_TRAP: tgt = trap_vec;
      default:   tgt = bra_addr;
    endcase
  end

  // trap_vec is trusted; only computed targets are alignment-checked.
  assign misal     = (redir_type != TYPE_TRAP) && (tgt[1:0] != 2'b00);
  assign final_tgt = misal ? trap_vec : tgt;
  assign is_trap   = (redir_type == TYPE_TRAP) || misal;

  // A buffered trap must not be lost to a later ordinary redirect.
  assign keep_pending = pend_trap && !is_trap;
  assign hold_tgt     = (redir_valid && !keep_pending) ? final_tgt : pend_tgt;
  assign hold_trap    = (redir_valid && !keep_pending) ? is_trap   : pend_trap;

  assign fetch_valid  = (state == RUN) && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      fetch_pc      <= RESET_VECTOR;
      pend_tgt      <= '0;
      pend_trap     <= 1'b0;
      redir_pending <= 1'b0;
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
`ifdef PC_GEN_REDIR_CNT_EN
      redir_count   <= '0;
`endif
    end else begin
      misalign_trap <= 1'b0;
      if (redir_valid && misal) begin
        misalign_trap <= 1'b1;
        misalign_addr <= tgt;
      end

      case (state)
        BOOT, RUN: begin
          if (redir_valid) begin
            if (stall) begin
              pend_tgt      <= final_tgt;
              pend_trap     <= is_trap;
              redir_pending <= 1'b1;
              state         <= HOLD;
            end else begin
              fetch_pc <= final_tgt;
              state    <= RUN;
`ifdef PC_GEN_REDIR_CNT_EN
              redir_count <= redir_count + 32'd1;
`endif
            end
          end else begin
            if (fetch_valid && fetch_ready) begin
              fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            state <= RUN;
          end
        end

        HOLD: begin
          if (!stall) begin
            fetch_pc      <= hold_tgt;
            pend_trap     <= 1'b0;
            redir_pending <= 1'b0;
            state         <= RUN;
`ifdef PC_GEN_REDIR_CNT_EN
            redir_count   <= redir_count + 32'd1;
`endif
          end else begin
            pend_tgt  <= hold_tgt;
            pend_trap <= hold_trap;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
